// File: rtl/score_hex_pkg.sv
// Shared types and the active-low 7-segment table for the score display.
package score_hex_pkg;

  // Winner-digit display state.
  typedef enum logic [1:0] {
    StIdle,
    StBlinkOn,
    StBlinkOff,
    StHold
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit 6 = g. Entry n shows digit n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_digit_decode.sv
// Combinational 4-bit to active-low 7-segment decode; 10..15 show blank.
module hex_digit_decode
  import score_hex_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Table lookup with blank as the default for non-decimal values.
  always_comb begin
    seg_o = SEG_BLANK;
    for (int i = 0; i < 10; i++) begin
      if (value_i == 4'(i)) seg_o = SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/score_hex_display.sv
// Per-player round score tracker with 7-segment outputs and a blinking
// last-winner digit. All outputs are decoded from registers only.
module score_hex_display
  import score_hex_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_MAX   = 7,
  parameter int unsigned BLINK_HALF  = 25,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PLAYERS-1:0]      win,
  input  logic                        clear_scores,
  output logic [NUM_PLAYERS-1:0][6:0] hex_score,
  output logic [6:0]                  hex_winner,
  output logic                        game_over
);

  localparam int unsigned PhaseW  = $clog2(BLINK_HALF + 1);
  localparam int unsigned PeriodW = $clog2(BLINK_COUNT + 1);

  logic [NUM_PLAYERS-1:0]      win_prev_q;
  logic [NUM_PLAYERS-1:0]      rise;
  logic [NUM_PLAYERS-1:0]      grant;
  logic [NUM_PLAYERS-1:0][3:0] score_q, score_d;
  logic                        game_over_q, game_over_d;
  logic [3:0]                  win_num_q, win_num_d;
  state_e                      state_q, state_d;
  logic [PhaseW-1:0]           phase_q, phase_d;
  logic [PeriodW-1:0]          period_q, period_d;
  logic [PeriodW-1:0]          period_inc;
  logic                        phase_end;
  logic [6:0]                  winner_seg;

  assign rise       = win & ~win_prev_q;
  // Isolate the lowest set rise bit: lower player index wins ties.
  assign grant      = rise & (~rise + NUM_PLAYERS'(1));
  assign phase_end  = (phase_q == PhaseW'(BLINK_HALF - 1));
  assign period_inc = period_q + PeriodW'(1);

  // Next-state: blink sequencing, then clear / accepted win override it.
  always_comb begin
    score_d     = score_q;
    game_over_d = game_over_q;
    win_num_d   = win_num_q;
    state_d     = state_q;
    phase_d     = phase_q;
    period_d    = period_q;

    unique case (state_q)
      StBlinkOn: begin
        if (phase_end) begin
          state_d = StBlinkOff;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StBlinkOff: begin
        if (phase_end) begin
          phase_d  = '0;
          period_d = period_inc;
          state_d  = (period_inc == PeriodW'(BLINK_COUNT)) ? StHold : StBlinkOn;
        end else begin
          phase_d = phase_q + PhaseW'(1);
        end
      end
      StIdle, StHold: ;
      default: ;
    endcase

    if (clear_scores) begin
      score_d     = '0;
      game_over_d = 1'b0;
      win_num_d   = '0;
      state_d     = StIdle;
      phase_d     = '0;
      period_d    = '0;
    end else if (!game_over_q && (|rise)) begin
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        if (grant[i]) begin
          if (score_q[i] < 4'(SCORE_MAX)) score_d[i] = score_q[i] + 4'd1;
          if (score_q[i] + 4'd1 == 4'(SCORE_MAX)) game_over_d = 1'b1;
          win_num_d = 4'(i + 1);
        end
      end
      state_d  = StBlinkOn;
      phase_d  = '0;
      period_d = '0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_prev_q  <= '0;
      score_q     <= '0;
      game_over_q <= 1'b0;
      win_num_q   <= '0;
      state_q     <= StIdle;
      phase_q     <= '0;
      period_q    <= '0;
    end else begin
      win_prev_q  <= win;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      win_num_q   <= win_num_d;
      state_q     <= state_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score_dec
    hex_digit_decode u_score_dec (
      .value_i (score_q[g]),
      .seg_o   (hex_score[g])
    );
  end

  hex_digit_decode u_winner_dec (
    .value_i (win_num_q),
    .seg_o   (winner_seg)
  );

  // Winner digit visible only in the ON half of a blink and while holding.
  always_comb begin
    hex_winner = SEG_BLANK;
    if (state_q == StBlinkOn || state_q == StHold) hex_winner = winner_seg;
  end

  assign game_over = game_over_q;

endmodule
